// File: rtl/multi_zone_temp_pkg.sv
// Shared definitions for the multi-zone temperature controller.
//   zone_state_t : per-zone FSM state (IDLE, HEAT, COOL, LOCKOUT)
//   cnt_w        : width needed for a counter that must reach a given value
//   sat_sub      : a - b, clamped at 0
//   sat_add      : a + b, clamped at 2^w - 1
// The threshold helpers work on 32-bit values, so temperatures up to 31
// bits wide always keep the carry/borrow bit.
package multi_zone_temp_pkg;

  typedef enum logic [1:0] {
    ZS_IDLE    = 2'd0,
    ZS_HEAT    = 2'd1,
    ZS_COOL    = 2'd2,
    ZS_LOCKOUT = 2'd3
  } zone_state_t;

  function automatic int cnt_w(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

  function automatic logic [31:0] sat_sub(input logic [31:0] a, input logic [31:0] b);
    return (a > b) ? (a - b) : 32'd0;
  endfunction

  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b,
                                          input int w);
    logic [32:0] sum;
    logic [32:0] lim;
    sum = {1'b0, a} + {1'b0, b};
    lim = (33'd1 << w) - 33'd1;
    return (sum > lim) ? lim[31:0] : sum[31:0];
  endfunction

endpackage

// File: rtl/multi_zone_temp_ctrl_zone.sv
// tc_zone_fsm: one temperature zone. It computes the hysteresis thresholds,
// raises a request toward the shared budget arbiter and runs the
// IDLE/HEAT/COOL/LOCKOUT state machine with its on/off (and optional
// watchdog run) counters.
// Optional feature macro: ATC_WATCHDOG_EN (run counter and sticky fault).
// Ports:
//   clk, reset         clock, synchronous active-low reset
//   en                 zone enable
//   current_temp       measured temperature
//   desired_temp       set point
//   temp_tolerance     hysteresis half-band
//   fault_clr          clears a latched watchdog fault
//   grant              budget slot granted this cycle
//   req                zone wants a slot
//   heater_on          heater drive (state HEAT)
//   cooler_on          cooler drive (state COOL)
//   fault              sticky watchdog fault
//   state              current FSM state (debug / active counting)
//
// Request/grant: req is combinational from registered state and the current
// inputs, and is only high in IDLE. The arbiter may assert grant only in a
// cycle where req is high; a grant is consumed at that same clock edge and
// there is no holding of either signal across cycles.
module tc_zone_fsm
  import multi_zone_temp_pkg::*;
#(
  parameter int TEMP_W  = 8,
  parameter int TOL_W   = 4,
  parameter int MIN_ON  = 8,
  parameter int MIN_OFF = 6,
  parameter int MAX_RUN = 4096
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic [TEMP_W-1:0] current_temp,
  input  logic [TEMP_W-1:0] desired_temp,
  input  logic [TOL_W-1:0]  temp_tolerance,
  input  logic              fault_clr,
  input  logic              grant,
  output logic              req,
  output logic              heater_on,
  output logic              cooler_on,
  output logic              fault,
  output zone_state_t       state
);

  localparam int ON_W  = cnt_w(MIN_ON);
  localparam int OFF_W = cnt_w(MIN_OFF);
  localparam logic [ON_W-1:0]  ON_LIM  = ON_W'(MIN_ON);
  localparam logic [OFF_W-1:0] OFF_LIM = OFF_W'(MIN_OFF);

  zone_state_t      state_n;
  logic [ON_W-1:0]  on_cnt, on_n;
  logic [OFF_W-1:0] off_cnt, off_n;
  logic [31:0]      cur, des, lo, hi;
  logic             want_heat, want_cool, on_sat, done, trip;

  assign cur = 32'(current_temp);
  assign des = 32'(desired_temp);
  assign lo  = sat_sub(des, 32'(temp_tolerance));
  assign hi  = sat_add(des, 32'(temp_tolerance), TEMP_W);

  assign want_heat = cur < lo;
  assign want_cool = cur > hi;
  assign req       = (state == ZS_IDLE) && en && !fault && (want_heat || want_cool);

  assign heater_on = (state == ZS_HEAT);
  assign cooler_on = (state == ZS_COOL);

  // A run may only end normally once it has been on for MIN_ON cycles and the
  // zone has reached (not merely entered the band around) the set point.
  assign on_sat = (on_cnt >= ON_LIM);
  assign done   = on_sat && ((heater_on && cur >= des) || (cooler_on && cur <= des));

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= ZS_IDLE;
      on_cnt  <= '0;
      off_cnt <= '0;
    end else begin
      state   <= state_n;
      on_cnt  <= on_n;
      off_cnt <= off_n;
    end
  end

  always_comb begin
    state_n = state;
    on_n    = on_cnt;
    off_n   = off_cnt;
    case (state)
      ZS_IDLE: begin
        if (grant && want_heat) begin
          state_n = ZS_HEAT;
          on_n    = ON_W'(1);
        end else if (grant && want_cool) begin
          state_n = ZS_COOL;
          on_n    = ON_W'(1);
        end
      end
      ZS_HEAT, ZS_COOL: begin
        // Disable overrides MIN_ON; every exit passes through LOCKOUT so a
        // direct heat/cool reversal cannot happen.
        if (!en || done || trip) begin
          state_n = ZS_LOCKOUT;
          off_n   = OFF_W'(1);
        end else if (!on_sat) begin
          on_n = on_cnt + 1'b1;
        end
      end
      ZS_LOCKOUT: begin
        if (off_cnt >= OFF_LIM) begin
          state_n = ZS_IDLE;
        end else begin
          off_n = off_cnt + 1'b1;
        end
      end
      default: state_n = ZS_IDLE;
    endcase
  end

`ifdef ATC_WATCHDOG_EN
  localparam int RUN_W = cnt_w(MAX_RUN);
  localparam logic [RUN_W-1:0] RUN_LIM = RUN_W'(MAX_RUN);

  logic [RUN_W-1:0] run_cnt;

  // A run that ends normally on the same edge is not a watchdog trip.
  assign trip = (heater_on || cooler_on) && en && !done && (run_cnt >= RUN_LIM);

  always_ff @(posedge clk) begin
    if (!reset) begin
      run_cnt <= '0;
      fault   <= 1'b0;
    end else begin
      if (heater_on || cooler_on) begin
        if (run_cnt != RUN_LIM) run_cnt <= run_cnt + 1'b1;
      end else begin
        run_cnt <= grant ? RUN_W'(1) : '0;
      end
      // A trip in the same cycle as a clear leaves the fault set.
      if (trip) begin
        fault <= 1'b1;
      end else if (fault_clr) begin
        fault <= 1'b0;
      end
    end
  end
`else
  assign trip = 1'b0;

  // Without the watchdog nothing can set the fault, so it stays at its reset
  // value of 0 and a clear pulse has no visible effect.
  always_ff @(posedge clk) begin
    if (!reset) begin
      fault <= 1'b0;
    end else if (fault_clr || (MAX_RUN < 1)) begin
      fault <= 1'b0;
    end
  end
`endif

endmodule

// File: rtl/multi_zone_temp_ctrl.sv
// multi_zone_temp_ctrl: NUM_ZONES heater/cooler pairs with hysteresis,
// minimum on/off dwell and a shared power budget of MAX_ACTIVE simultaneous
// actuators granted round-robin.
// Optional feature macro: ATC_WATCHDOG_EN (per-zone run watchdog, MAX_RUN).
// Ports:
//   clk            system clock (rising edge)
//   reset          synchronous active-low reset
//   zone_en        per-zone enable
//   current_temp   packed temperatures, zone i at [i*TEMP_W +: TEMP_W]
//   desired_temp   packed set points, same layout
//   temp_tolerance hysteresis band shared by all zones
//   fault_clr      per-zone fault clear pulse
//   heater_on      per-zone heater drive
//   cooler_on      per-zone cooler drive
//   zone_fault     per-zone sticky watchdog fault
//   active_cnt     number of zones currently in HEAT or COOL
module multi_zone_temp_ctrl
  import multi_zone_temp_pkg::*;
#(
  parameter int NUM_ZONES  = 4,
  parameter int TEMP_W     = 8,
  parameter int TOL_W      = 4,
  parameter int MIN_ON     = 8,
  parameter int MIN_OFF    = 6,
  parameter int MAX_ACTIVE = 2,
  parameter int MAX_RUN    = 4096
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_ZONES-1:0]          zone_en,
  input  logic [NUM_ZONES*TEMP_W-1:0]   current_temp,
  input  logic [NUM_ZONES*TEMP_W-1:0]   desired_temp,
  input  logic [TOL_W-1:0]              temp_tolerance,
  input  logic [NUM_ZONES-1:0]          fault_clr,
  output logic [NUM_ZONES-1:0]          heater_on,
  output logic [NUM_ZONES-1:0]          cooler_on,
  output logic [NUM_ZONES-1:0]          zone_fault,
  output logic [$clog2(NUM_ZONES+1)-1:0] active_cnt
);

  localparam int AW  = $clog2(NUM_ZONES + 1);
  localparam int PW  = (NUM_ZONES > 1) ? $clog2(NUM_ZONES) : 1;
  localparam int PW1 = PW + 1;

  logic [NUM_ZONES-1:0] req, grant, active;
  zone_state_t          zone_state [NUM_ZONES];
  logic [PW-1:0]        rr, rr_n, idx;
  logic [PW1-1:0]       pos, nxt;
  logic [AW-1:0]        cnt_sum, free, n_granted;

  for (genvar g = 0; g < NUM_ZONES; g++) begin : g_zone
    tc_zone_fsm #(
      .TEMP_W (TEMP_W),
      .TOL_W  (TOL_W),
      .MIN_ON (MIN_ON),
      .MIN_OFF(MIN_OFF),
      .MAX_RUN(MAX_RUN)
    ) u_zone (
      .clk           (clk),
      .reset         (reset),
      .en            (zone_en[g]),
      .current_temp  (current_temp[g*TEMP_W +: TEMP_W]),
      .desired_temp  (desired_temp[g*TEMP_W +: TEMP_W]),
      .temp_tolerance(temp_tolerance),
      .fault_clr     (fault_clr[g]),
      .grant         (grant[g]),
      .req           (req[g]),
      .heater_on     (heater_on[g]),
      .cooler_on     (cooler_on[g]),
      .fault         (zone_fault[g]),
      .state         (zone_state[g])
    );
    assign active[g] = (zone_state[g] == ZS_HEAT) || (zone_state[g] == ZS_COOL);
  end

  // Counted from registered zone states, so a slot freed at this edge only
  // becomes available to the arbiter on the following edge.
  always_comb begin
    cnt_sum = '0;
    for (int i = 0; i < NUM_ZONES; i++) begin
      cnt_sum = cnt_sum + AW'(active[i]);
    end
  end

  assign active_cnt = cnt_sum;
  assign free       = AW'(MAX_ACTIVE) - cnt_sum;

  // Scan zones starting at the round-robin pointer, wrapping once, and grant
  // requesters until the free slots are used up. The pointer lands one past
  // the last zone granted this cycle.
  always_comb begin
    grant     = '0;
    rr_n      = rr;
    n_granted = '0;
    pos       = '0;
    nxt       = '0;
    idx       = '0;
    for (int i = 0; i < NUM_ZONES; i++) begin
      pos = {1'b0, rr} + PW1'(i);
      if (pos >= PW1'(NUM_ZONES)) pos = pos - PW1'(NUM_ZONES);
      idx = pos[PW-1:0];
      if (req[idx] && (n_granted < free)) begin
        grant[idx] = 1'b1;
        n_granted  = n_granted + 1'b1;
        nxt        = pos + 1'b1;
        rr_n       = (nxt == PW1'(NUM_ZONES)) ? '0 : nxt[PW-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rr <= '0;
    end else begin
      rr <= rr_n;
    end
  end

endmodule

// File: doc/multi_zone_temp_ctrl.md
# multi_zone_temp_ctrl

Multi-zone successor to the single-zone auto temperature controller. Drives NUM_ZONES independent heater/cooler pairs from per-zone current/desired temperatures, adding hysteresis, minimum on/off dwell times and a shared power budget that caps simultaneously active actuators, granted round-robin. Sits between the sensor front-end and the actuator drivers; the bench environment model (heater/cooler stepping current_temp) is reused per zone.

## Interface
- NUM_ZONES, 4, number of zones (1..16)
- TEMP_W, 8, temperature width, unsigned
- TOL_W, 4, tolerance width, unsigned
- MIN_ON, 8, minimum cycles an actuator stays on once granted (>=1)
- MIN_OFF, 6, lockout cycles after any actuator turns off (>=1)
- MAX_ACTIVE, 2, max zones with heater or cooler on at once (1..NUM_ZONES)
- MAX_RUN, 4096, watchdog limit in cycles (used only with ATC_WATCHDOG_EN)

- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-low reset
- zone_en  in  NUM_ZONES  per-zone enable
- current_temp  in  NUM_ZONES*TEMP_W  packed, zone i at [i*TEMP_W +: TEMP_W]
- desired_temp  in  NUM_ZONES*TEMP_W  packed, same layout
- temp_tolerance  in  TOL_W  hysteresis band, shared by all zones
- fault_clr  in  NUM_ZONES  per-zone fault clear pulse
- heater_on  out  NUM_ZONES  registered heater drive
- cooler_on  out  NUM_ZONES  registered cooler drive
- zone_fault  out  NUM_ZONES  sticky watchdog fault
- active_cnt  out  $clog2(NUM_ZONES+1)  zones currently HEAT or COOL

## Operation
- Per-zone FSM: IDLE, HEAT, COOL, LOCKOUT. Reset: all zones IDLE, counters 0, all outputs 0, RR pointer 0.
- Thresholds: lo = desired - tol saturating at 0; hi = desired + tol saturating at 2^TEMP_W-1; computed at TEMP_W+1 bits.
- IDLE: requests heat if current < lo, cool if current > hi, else none. Request granted only if zone_en=1, no fault, and a budget slot is free.
- Grant: free = MAX_ACTIVE - active_cnt (registered). Up to `free` requesting zones granted per cycle, scanned from RR pointer upward with wrap; pointer moves to one past the last granted zone, unchanged if none granted.
- HEAT: on-counter counts; exit to LOCKOUT when counter >= MIN_ON and current >= desired. COOL symmetric with current <= desired.
- LOCKOUT: actuators off for MIN_OFF cycles, then IDLE. Direct HEAT<->COOL transition forbidden.
- zone_en=0 in HEAT/COOL: immediate LOCKOUT, overriding MIN_ON.
- heater_on and cooler_on never both 1 for a zone; active_cnt never exceeds MAX_ACTIVE.
- Slot released this cycle is not reusable until the next cycle (budget uses registered state).
- desired_temp change mid-run takes effect on the next comparison; no restart of counters.

## Timing
- Inputs sampled at edge k; heater_on/cooler_on change at edge k (visible after k), i.e. one-cycle latency from threshold crossing to drive.
- Minimum on pulse exactly MIN_ON cycles; minimum gap between off and next on of the same zone exactly MIN_OFF+1 cycles (LOCKOUT plus IDLE grant cycle).
- reset low at any edge: all outputs 0 after that edge, in-progress runs aborted, faults cleared.

## Configuration
- ATC_WATCHDOG_EN defined: per-zone run counter; HEAT/COOL lasting MAX_RUN cycles without exit sets zone_fault, forces LOCKOUT, blocks grants until fault_clr pulse (clear takes effect next cycle; fault_clr and trip in same cycle: trip wins).
- Undefined: no run counter, zone_fault tied 0, fault_clr ignored.

## Structure
- Package multi_zone_temp_pkg: zone state enum (IDLE, HEAT, COOL, LOCKOUT), threshold saturating-function, counter width helpers.
- Sub-module tc_zone_fsm (one per zone, generate loop): thresholds, FSM, on/off/run counters. Top holds RR budget arbiter and active_cnt.

## Test plan
- 1 zone, current=60, desired=70, tol=2, env model: heater_on at next edge, stays >= MIN_ON, drops when temp >= 70, LOCKOUT 6 cycles, no re-fire while 68..72.
- current=80, desired=70: cooler_on, off at <= 70; heater never asserted in same run.
- 4 zones all cold (40 vs 70), MAX_ACTIVE=2: never more than 2 active; grants rotate 0,1 then 2,3 in order.
- zone_en dropped 3 cycles into HEAT: heater_on 0 next edge, zone in LOCKOUT 6 cycles.
- ATC_WATCHDOG_EN, MAX_RUN=100, heater with env frozen: zone_fault=1 at cycle 100, heater 0, no regrant until fault_clr.
- reset low mid-run with 2 active zones: all outputs and active_cnt 0 after that edge; normal restart after release.
